// File: rtl/tft_timing_gen_if.sv
// Signal bundle between pixel source, timing generator and panel pins.
// master = timing generator side, slave = pixel source / panel side.
interface tft_timing_gen_if #(
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int BPC      = 8,
  parameter int PWM_BITS = 8
);
  logic                enable;
  logic [PWM_BITS-1:0] brightness;
  logic [3*BPC-1:0]    color;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic                req_active;
  logic                new_frame;
  logic                ready;
  logic                tft_vdd;
  logic                tft_display;
  logic                tft_backlight;
  logic                tft_hsync;
  logic                tft_vsync;
  logic                tft_data_ena;
  logic [7:0]          tft_red;
  logic [7:0]          tft_green;
  logic [7:0]          tft_blue;

  modport master (
    input  enable, brightness, color,
    output x, y, req_active, new_frame, ready,
    output tft_vdd, tft_display, tft_backlight,
    output tft_hsync, tft_vsync, tft_data_ena,
    output tft_red, tft_green, tft_blue
  );

  modport slave (
    output enable, brightness, color,
    input  x, y, req_active, new_frame, ready,
    input  tft_vdd, tft_display, tft_backlight,
    input  tft_hsync, tft_vsync, tft_data_ena,
    input  tft_red, tft_green, tft_blue
  );
endinterface

// File: rtl/tft_timing_gen.sv
// TFT raster timing generator with panel power sequencing and PWM backlight.
// Coordinates lead the pins by LATENCY+1 clocks to hide source pipeline latency.
module tft_timing_gen #(
  parameter int H_ACTIVE       = 800,
  parameter int H_FP           = 40,
  parameter int H_SYNC         = 48,
  parameter int H_BP           = 40,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 13,
  parameter int V_SYNC         = 3,
  parameter int V_BP           = 29,
  parameter int BITS_PER_COLOR = 8,
  parameter int LATENCY        = 2,
  parameter int PWM_BITS       = 8,
  parameter int PWR_DELAY      = 1024
) (
  input  logic             tft_clk,
  input  logic             rst,
  tft_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int CW      = (PWR_DELAY > 1) ? $clog2(PWR_DELAY) : 1;
  localparam int B       = BITS_PER_COLOR;

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWR_DELAY - 1);

  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] HA     = 32'(H_ACTIVE);
  localparam logic [31:0] VA     = 32'(V_ACTIVE);

  if (BITS_PER_COLOR < 1 || BITS_PER_COLOR > 8) begin : g_bpc_chk
    $error("BITS_PER_COLOR must be 1..8");
  end
  if (LATENCY < 0 || LATENCY > H_FP) begin : g_lat_chk
    $error("LATENCY must be 0..H_FP");
  end
  if (V_FP + V_SYNC + V_BP < 1) begin : g_vblank_chk
    $error("vertical blanking must be at least one line");
  end
  if (PWR_DELAY < 1) begin : g_pwr_chk
    $error("PWR_DELAY must be at least 1");
  end

  typedef enum logic [2:0] {
    S_OFF,
    S_VDD_UP,
    S_DISP_UP,
    S_RUN,
    S_DISP_DOWN,
    S_VDD_DOWN
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                bl_q, bl_d;

  logic       vdd, disp, run;
  logic       step_done, timed;
  logic       x_last, y_last, frame_end;
  logic [31:0] xw, yw;
  logic       de_req, hs_req, vs_req;
  logic       de_al, hs_al, vs_al;

  logic       de_pin_q, de_pin_d;
  logic       hs_pin_q, hs_pin_d;
  logic       vs_pin_q, vs_pin_d;
  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;

  // Stretch a B-bit channel to 8 bits by repeating its MSBs into the LSBs.
  function automatic logic [7:0] expand(input logic [B-1:0] c);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[7-i] = c[B-1-(i % B)];
    end
    return o;
  endfunction

  assign step_done = (cnt_q == CNT_LAST);
  assign x_last    = (x_q == X_LAST);
  assign y_last    = (y_q == Y_LAST);
  assign frame_end = x_last && y_last;

  // Power-sequencing state register.
  always_ff @(posedge tft_clk) begin
    if (rst) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enable only matters in OFF and RUN; ramps always complete.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:       if (bus.enable) state_d = S_VDD_UP;
      S_VDD_UP:    if (step_done)  state_d = S_DISP_UP;
      S_DISP_UP:   if (step_done)  state_d = S_RUN;
      S_RUN:       if (frame_end && (stop_q || !bus.enable))
                     state_d = S_DISP_DOWN;
      S_DISP_DOWN: if (step_done)  state_d = S_VDD_DOWN;
      S_VDD_DOWN:  if (step_done)  state_d = S_OFF;
      default:                     state_d = S_OFF;
    endcase
  end

  // Power rails and run flag decoded from the current state.
  always_comb begin
    vdd  = 1'b0;
    disp = 1'b0;
    run  = 1'b0;
    unique case (state_q)
      S_VDD_UP:    vdd = 1'b1;
      S_DISP_UP:   begin vdd = 1'b1; disp = 1'b1; end
      S_RUN:       begin vdd = 1'b1; disp = 1'b1; run = 1'b1; end
      S_DISP_DOWN: begin vdd = 1'b1; disp = 1'b1; end
      S_VDD_DOWN:  vdd = 1'b1;
      default:     ;
    endcase
  end

  // Step timer restarts on every state change; a low enable seen
  // anywhere in a frame is remembered until that frame ends.
  always_comb begin
    timed  = (state_q == S_VDD_UP) || (state_q == S_DISP_UP) ||
             (state_q == S_DISP_DOWN) || (state_q == S_VDD_DOWN);
    cnt_d  = (timed && state_d == state_q) ? cnt_q + CW'(1) : '0;
    stop_d = run && (stop_q || !bus.enable);
  end

  // Step timer and shutdown-request flops.
  always_ff @(posedge tft_clk) begin
    if (rst) begin
      cnt_q  <= '0;
      stop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      stop_q <= stop_d;
    end
  end

  // Raster counters advance only in RUN and sit at the origin otherwise.
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (run) begin
      x_d = x_last ? '0 : x_q + XW'(1);
      y_d = y_q;
      if (x_last) begin
        y_d = y_last ? '0 : y_q + YW'(1);
      end
    end
  end

  // Raster coordinate registers.
  always_ff @(posedge tft_clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign xw = 32'(x_q);
  assign yw = 32'(y_q);

  // Request-side flags; blanking values are injected outside RUN.
  always_comb begin
    de_req = run && (xw < HA) && (yw < VA);
    hs_req = !(run && (xw >= HS_BEG) && (xw < HS_END));
    vs_req = !(run && (yw >= VS_BEG) && (yw < VS_END));
  end

  if (LATENCY == 0) begin : g_nopipe
    assign de_al = de_req;
    assign hs_al = hs_req;
    assign vs_al = vs_req;
  end else begin : g_pipe
    logic [LATENCY-1:0] de_p_q, de_p_d;
    logic [LATENCY-1:0] hs_p_q, hs_p_d;
    logic [LATENCY-1:0] vs_p_q, vs_p_d;

    // Delay flags so they meet the colour of the same coordinate.
    always_comb begin
      de_p_d    = de_p_q;
      hs_p_d    = hs_p_q;
      vs_p_d    = vs_p_q;
      de_p_d[0] = de_req;
      hs_p_d[0] = hs_req;
      vs_p_d[0] = vs_req;
      for (int i = 1; i < LATENCY; i++) begin
        de_p_d[i] = de_p_q[i-1];
        hs_p_d[i] = hs_p_q[i-1];
        vs_p_d[i] = vs_p_q[i-1];
      end
    end

    // Alignment shift registers, flushed to blanking on reset.
    always_ff @(posedge tft_clk) begin
      if (rst) begin
        de_p_q <= '0;
        hs_p_q <= '1;
        vs_p_q <= '1;
      end else begin
        de_p_q <= de_p_d;
        hs_p_q <= hs_p_d;
        vs_p_q <= vs_p_d;
      end
    end

    assign de_al = de_p_q[LATENCY-1];
    assign hs_al = hs_p_q[LATENCY-1];
    assign vs_al = vs_p_q[LATENCY-1];
  end

  // Pin values: colour is blanked to zero wherever the aligned de is low.
  always_comb begin
    de_pin_d = de_al;
    hs_pin_d = hs_al;
    vs_pin_d = vs_al;
    r_d      = '0;
    g_d      = '0;
    b_d      = '0;
    if (de_al) begin
      r_d = expand(bus.color[3*B-1 -: B]);
      g_d = expand(bus.color[2*B-1 -: B]);
      b_d = expand(bus.color[B-1:0]);
    end
  end

  // Panel pin registers.
  always_ff @(posedge tft_clk) begin
    if (rst) begin
      de_pin_q <= 1'b0;
      hs_pin_q <= 1'b1;
      vs_pin_q <= 1'b1;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      de_pin_q <= de_pin_d;
      hs_pin_q <= hs_pin_d;
      vs_pin_q <= vs_pin_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  // PWM counter restarts on RUN entry; backlight is off in every other state.
  always_comb begin
    pwm_d = '0;
    if (state_d == S_RUN && state_q == S_RUN) begin
      pwm_d = pwm_q + PWM_BITS'(1);
    end
    bl_d = (state_d == S_RUN) && (pwm_d < bus.brightness);
  end

  // Backlight PWM registers.
  always_ff @(posedge tft_clk) begin
    if (rst) begin
      pwm_q <= '0;
      bl_q  <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      bl_q  <= bl_d;
    end
  end

  assign bus.x             = x_q;
  assign bus.y             = y_q;
  assign bus.req_active    = de_req;
  assign bus.new_frame     = run && (x_q == '0) && (y_q == '0);
  assign bus.ready         = run;
  assign bus.tft_vdd       = vdd;
  assign bus.tft_display   = disp;
  assign bus.tft_backlight = bl_q;
  assign bus.tft_hsync     = hs_pin_q;
  assign bus.tft_vsync     = vs_pin_q;
  assign bus.tft_data_ena  = de_pin_q;
  assign bus.tft_red       = r_q;
  assign bus.tft_green     = g_q;
  assign bus.tft_blue      = b_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench for tft_timing_gen on a 14x7 raster.
// Tables cover colour expansion and PWM duty; sequences cover power and reset.
module tb_tft_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int LAT = 2;
  localparam int PIN_LAT = LAT + 1;
  localparam int BPC = 5;
  localparam int PD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tft_timing_gen_if #(.XW(4), .YW(3), .BPC(BPC), .PWM_BITS(8)) bus ();

  tft_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BITS_PER_COLOR(BPC), .LATENCY(LAT),
    .PWM_BITS(8), .PWR_DELAY(PD)
  ) dut (
    .tft_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [4:0] fr(input int xx, input int yy);
    return 5'(xx + 8 * yy);
  endfunction
  function automatic logic [4:0] fg(input int xx, input int yy);
    return 5'(31 - xx - yy);
  endfunction
  function automatic logic [4:0] fb(input int xx, input int yy);
    return 5'((3 * xx) ^ yy);
  endfunction
  function automatic logic [7:0] exp8(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Pixel source model: colour for the coordinate seen LAT clocks ago.
  logic       const_mode = 1'b0;
  logic [4:0] cr = '0;
  int h1x = 0, h1y = 0, h2x = 0, h2y = 0;
  always @(negedge clk) begin
    if (const_mode) bus.color = {cr, cr, cr};
    else bus.color = {fr(h2x, h2y), fg(h2x, h2y), fb(h2x, h2y)};
    h2x = h1x;
    h2y = h1y;
    h1x = int'(bus.x);
    h1y = int'(bus.y);
  end

  task automatic check_reset(input string tag);
    check({tag, "_pwr"}, {bus.tft_vdd, bus.tft_display, bus.tft_backlight}, 3'b000);
    check({tag, "_sync"}, {bus.tft_hsync, bus.tft_vsync}, 2'b11);
    check({tag, "_de"}, bus.tft_data_ena, 1'b0);
    check({tag, "_rgb"}, {bus.tft_red, bus.tft_green, bus.tft_blue}, 24'h0);
    check({tag, "_xy"}, {bus.x, bus.y}, 7'h0);
    check({tag, "_flags"}, {bus.req_active, bus.new_frame, bus.ready}, 3'b000);
  endtask

  typedef struct {
    logic [4:0] c;
    logic [7:0] e;
  } col_vec_t;

  typedef struct {
    logic [7:0] b;
    int         n;
  } pwm_vec_t;

  col_vec_t ctab[5];
  pwm_vec_t ptab[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lx, ly, n_nf, nf_at;
    int bad_de, bad_hs, bad_vs, bad_col, bad_xy;
    int n_de, n_hs, n_vs;

    ctab[0] = '{5'h1F, 8'hFF};
    ctab[1] = '{5'h10, 8'h84};
    ctab[2] = '{5'h00, 8'h00};
    ctab[3] = '{5'h01, 8'h08};
    ctab[4] = '{5'h15, 8'hAD};

    ptab[0] = '{8'd64, 64};
    ptab[1] = '{8'd0, 0};
    ptab[2] = '{8'd255, 255};
    ptab[3] = '{8'd1, 1};
    ptab[4] = '{8'd200, 200};

    bus.enable = 1'b0;
    bus.brightness = 8'd128;
    repeat (3) step();
    check_reset("rst0");
    rst = 1'b0;
    step();

    // Power-up: enable rises in cycle 0.
    bus.enable = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1 || c == 4 || c == 5 || c == 8 || c == 9)
        check($sformatf("pwrup_c%0d", c),
              {bus.tft_vdd, bus.tft_display, bus.ready, bus.new_frame},
              {1'b1, c >= 5, c >= 9, c == 9});
    end

    // Two frames of raster against the geometry, k=0 is the first RUN clock.
    bad_de = 0; bad_hs = 0; bad_vs = 0; bad_col = 0; bad_xy = 0;
    n_de = 0; n_hs = 0; n_vs = 0; n_nf = 0; nf_at = -1;
    for (int k = 0; k < 2 * FR; k++) begin
      int j, xr, yr, xk, yk;
      logic de_e, hs_e, vs_e;
      logic [23:0] col_e;
      if (k > 0) step();
      j = k - PIN_LAT;
      de_e = 1'b0; hs_e = 1'b1; vs_e = 1'b1; col_e = '0;
      if (j >= 0) begin
        xr = j % HT;
        yr = (j / HT) % VT;
        de_e = (xr < HA) && (yr < VA);
        hs_e = !((xr >= HA + HF) && (xr < HA + HF + HS));
        vs_e = !((yr >= VA + VF) && (yr < VA + VF + VS));
        if (de_e)
          col_e = {exp8(fr(xr, yr)), exp8(fg(xr, yr)), exp8(fb(xr, yr))};
      end
      xk = k % HT;
      yk = (k / HT) % VT;
      if (bus.tft_data_ena !== de_e) bad_de++;
      if (bus.tft_hsync !== hs_e) bad_hs++;
      if (bus.tft_vsync !== vs_e) bad_vs++;
      if ({bus.tft_red, bus.tft_green, bus.tft_blue} !== col_e) bad_col++;
      if (int'(bus.x) != xk || int'(bus.y) != yk ||
          bus.req_active !== (xk < HA && yk < VA) ||
          bus.new_frame !== (k % FR == 0)) bad_xy++;
      if (j >= 0 && j < FR) begin
        n_de += int'(bus.tft_data_ena);
        n_hs += int'(!bus.tft_hsync);
        n_vs += int'(!bus.tft_vsync);
      end
      if (bus.new_frame) begin
        n_nf++;
        if (k > 0) nf_at = k;
      end
    end
    check("raster_de", bad_de, 0);
    check("raster_hsync", bad_hs, 0);
    check("raster_vsync", bad_vs, 0);
    check("raster_color", bad_col, 0);
    check("raster_xy_flags", bad_xy, 0);
    check("de_clocks_per_frame", n_de, 32);
    check("hsync_low_per_frame", n_hs, 14);
    check("vsync_low_per_frame", n_vs, 14);
    check("frame_period", nf_at, FR);
    check("new_frame_count", n_nf, 2);

    // Colour expansion of a constant channel value.
    for (int i = 0; i < 5; i++) begin
      const_mode = 1'b1;
      cr = ctab[i].c;
      repeat (4) step();
      w = 0;
      while (!bus.tft_data_ena && w < 200) begin
        step();
        w++;
      end
      check($sformatf("expand_%0h", ctab[i].c),
            {bus.tft_data_ena, bus.tft_red, bus.tft_green, bus.tft_blue},
            {1'b1, ctab[i].e, ctab[i].e, ctab[i].e});
    end
    const_mode = 1'b0;

    // Backlight duty over one full PWM period.
    for (int i = 0; i < 5; i++) begin
      int hi;
      bus.brightness = ptab[i].b;
      repeat (2) step();
      hi = 0;
      for (int t = 0; t < 256; t++) begin
        step();
        hi += int'(bus.tft_backlight);
      end
      check($sformatf("pwm_%0d", ptab[i].b), hi, ptab[i].n);
    end
    bus.brightness = 8'd128;

    // Shutdown requested mid-line 1: frame completes first.
    w = 0;
    while (!(bus.y == 3'd1 && bus.x == 4'd3) && w < 200) begin
      step();
      w++;
    end
    check("sd_start", {bus.y, bus.x}, {3'd1, 4'd3});
    bus.enable = 1'b0;
    w = 0; lx = -1; ly = -1; n_nf = 0;
    while (bus.ready && w < 300) begin
      lx = int'(bus.x);
      ly = int'(bus.y);
      if (bus.new_frame) n_nf++;
      step();
      w++;
    end
    check("sd_run_clocks", w, 81);
    check("sd_last_xy", {lx[7:0], ly[7:0]}, {8'(HT - 1), 8'(VT - 1)});
    check("sd_no_new_frame", n_nf, 0);
    check("sd_d1_pins",
          {bus.tft_vdd, bus.tft_display, bus.tft_backlight, bus.tft_data_ena},
          4'b1100);
    for (int d = 2; d <= 10; d++) begin
      step();
      if (d == 2) begin
        check("sd_xy_held", {bus.x, bus.y}, 7'h0);
        bus.enable = 1'b1;
      end
      if (d == 4 || d == 5)
        check($sformatf("sd_display_d%0d", d), bus.tft_display, d == 4);
      if (d == 8 || d == 9 || d == 10)
        check($sformatf("sd_vdd_d%0d", d), bus.tft_vdd, d != 9);
    end
    for (int d = 11; d <= 18; d++) begin
      step();
      if (d == 17) check("repwr_ready_d17", bus.ready, 1'b0);
      if (d == 18) check("repwr_ready_d18", {bus.ready, bus.new_frame}, 2'b11);
    end

    // Reset mid-active-line drops everything on the next clock.
    w = 0;
    while (!(bus.y == 3'd2 && bus.x == 4'd4) && w < 200) begin
      step();
      w++;
    end
    check("pre_rst_de", {bus.y, bus.x, bus.tft_data_ena}, {3'd2, 4'd4, 1'b1});
    rst = 1'b1;
    step();
    check_reset("rst1");
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) check("rst_repwr_vdd", bus.tft_vdd, 1'b1);
      if (c == 8) check("rst_repwr_ready_c8", bus.ready, 1'b0);
      if (c == 9) check("rst_repwr_ready_c9", {bus.ready, bus.new_frame}, 2'b11);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
